// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM receive demultiplexer.
// The optional 16-bit frame counter is enabled by TDM_DEMUX_FRAME_CNT_EN.
package tdm_pkg;

    typedef enum logic {
        HUNT  = 1'b0,
        TRACK = 1'b1
    } tdm_state_e;

    localparam int FRAME_CNT_W = 16;

    // A slot index needs at least one bit even for the smallest legal frame.
    function automatic int tdm_slot_w(input int num_ch);
        if (num_ch <= 2) begin
            return 1;
        end else begin
            return $clog2(num_ch);
        end
    endfunction

endpackage

// File: rtl/tdm_slot_decoder.sv
// Combinational slot-index to one-hot channel enable decoder.
// Produces all zeros when the index is not qualified or names no channel.
module tdm_slot_decoder #(
    parameter int NUM_CH = 4,
    parameter int SLOT_W = 2
) (
    input  logic [SLOT_W-1:0] slot,
    input  logic              valid,
    output logic [NUM_CH-1:0] onehot
);

    // One enable bit per channel, only when the index is qualified
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            onehot[i] = valid && (slot == SLOT_W'(i));
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// 1-to-NUM_CH TDM demultiplexer with frame tracking and sync checking.
// Define TDM_DEMUX_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    input  logic                     frame_sync,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_valid,
    output logic                     frame_done,
    output logic                     sync_err
`ifdef TDM_DEMUX_FRAME_CNT_EN
    ,
    output logic [FRAME_CNT_W-1:0]   frame_cnt
`endif
);

    localparam int SLOT_W = tdm_slot_w(NUM_CH);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CH - 1);
    localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);

    tdm_state_e                state_r;
    tdm_state_e                state_nxt_s;
    logic [SLOT_W-1:0]         slot_r;
    logic [SLOT_W-1:0]         slot_nxt_s;
    logic [SLOT_W-1:0]         dst_slot_s;
    logic                      deliver_s;
    logic                      sync_err_s;
    logic                      frame_done_s;
    logic [NUM_CH-1:0]         we_s;
    logic [NUM_CH*DATA_W-1:0]  out_data_r;
    logic [NUM_CH-1:0]         out_valid_r;
    logic                      frame_done_r;
    logic                      sync_err_r;

    // Framing decisions for the current sample
    always_comb begin
        state_nxt_s  = state_r;
        slot_nxt_s   = slot_r;
        dst_slot_s   = '0;
        deliver_s    = 1'b0;
        sync_err_s   = 1'b0;
        frame_done_s = 1'b0;
        if (in_valid) begin
            case (state_r)
                HUNT: begin
                    if (frame_sync) begin
                        deliver_s   = 1'b1;
                        slot_nxt_s  = SLOT_ONE;
                        state_nxt_s = TRACK;
                    end else begin
                        state_nxt_s = HUNT;
                    end
                end
                TRACK: begin
                    if (frame_sync) begin
                        // A sync in the middle of a frame abandons it and restarts at ch0
                        sync_err_s = (slot_r != '0);
                        deliver_s  = 1'b1;
                        slot_nxt_s = SLOT_ONE;
                    end else if (slot_r == '0) begin
                        sync_err_s  = 1'b1;
                        slot_nxt_s  = '0;
                        state_nxt_s = HUNT;
                    end else begin
                        deliver_s  = 1'b1;
                        dst_slot_s = slot_r;
                        if (slot_r == LAST_SLOT) begin
                            frame_done_s = 1'b1;
                            slot_nxt_s   = '0;
                        end else begin
                            slot_nxt_s = slot_r + SLOT_ONE;
                        end
                    end
                end
                default: begin
                    state_nxt_s = HUNT;
                    slot_nxt_s  = '0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    tdm_slot_decoder #(
        .NUM_CH (NUM_CH),
        .SLOT_W (SLOT_W)
    ) u_slot_decoder (
        .slot   (dst_slot_s),
        .valid  (deliver_s),
        .onehot (we_s)
    );

    // State, slot counter and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= HUNT;
            slot_r       <= '0;
            out_data_r   <= '0;
            out_valid_r  <= '0;
            frame_done_r <= 1'b0;
            sync_err_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            slot_r       <= slot_nxt_s;
            out_valid_r  <= we_s;
            frame_done_r <= frame_done_s;
            sync_err_r   <= sync_err_s;
            for (int i = 0; i < NUM_CH; i++) begin
                if (we_s[i]) begin
                    out_data_r[i*DATA_W +: DATA_W] <= in_data;
                end
            end
        end
    end

    assign out_data   = out_data_r;
    assign out_valid  = out_valid_r;
    assign frame_done = frame_done_r;
    assign sync_err   = sync_err_r;

`ifdef TDM_DEMUX_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] frame_cnt_r;

    // Completed-frame counter, wraps naturally at its width
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_r <= '0;
        end else if (frame_done_s) begin
            frame_cnt_r <= frame_cnt_r + FRAME_CNT_W'(1);
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign frame_cnt = frame_cnt_r;
`endif

endmodule
